// File: rtl/tick_logger_pkg.sv
// -----------------------------------------------------------------------------
// tick_logger_pkg
//   Shared types and constants for the tick event logger: the queued entry
//   layout, the Avalon word-address map, and the bit positions inside the
//   STATUS and CONTROL registers.
// -----------------------------------------------------------------------------
package tick_logger_pkg;

    localparam int TS_WIDTH = 32;

    // One logged tick: its running number and the cycles since the previous tick.
    typedef struct packed {
        logic [TS_WIDTH-1:0] index;
        logic [TS_WIDTH-1:0] delta;
    } tick_entry_t;

    // Avalon word addresses
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_IDX_LO   = 3'd2;
    localparam logic [2:0] ADDR_IDX_HI   = 3'd3;
    localparam logic [2:0] ADDR_DELTA_LO = 3'd4;
    localparam logic [2:0] ADDR_DELTA_HI = 3'd5;
    localparam logic [2:0] ADDR_MISS     = 3'd6;

    // STATUS register bit positions
    localparam int STATUS_NOT_EMPTY = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERFLOW  = 2;
    localparam int STATUS_LEVEL_LSB = 8;

    // CONTROL register bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/tick_event_logger_if.sv
// -----------------------------------------------------------------------------
// tick_event_logger_if
//   16-bit Avalon-MM slave bus used to drain the tick logger.
//   address    : word address (3 bits)
//   chipselect : slave select
//   read_n     : active-low read strobe
//   write_n    : active-low write strobe
//   writedata  : 16-bit write data
//   readdata   : 16-bit registered read data, one cycle after the address
//   master modport drives the request side, slave modport returns readdata.
// -----------------------------------------------------------------------------
interface tick_event_logger_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/tick_log_fifo.sv
// -----------------------------------------------------------------------------
// tick_log_fifo
//   Synchronous show-ahead FIFO of tick entries. The head entry is visible
//   combinationally; push and pop in the same cycle are both honoured, even
//   when the FIFO is full (the popped slot receives the new tail).
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     push, pop  : write tail / discard head (pop ignored when empty,
//                  push ignored when full unless popping in the same cycle)
//     wdata      : entry to append
//     head       : oldest entry (undefined when empty)
//     level      : number of stored entries, 0..DEPTH
//     full, empty: occupancy flags
// -----------------------------------------------------------------------------
module tick_log_fifo
    import tick_logger_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  tick_entry_t                wdata,
    output tick_entry_t                head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    tick_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and level
    // alone decide which slots hold valid entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tick_event_logger.sv
// -----------------------------------------------------------------------------
// tick_event_logger
//   Watches the interval timer's irq, numbers and timestamps every rising
//   edge, and queues {tick index, cycles since previous tick} for software to
//   drain over a 16-bit Avalon-MM slave, so no timer period is lost to
//   interrupt latency.
//   Ports:
//     clk        : system clock
//     reset      : synchronous active-high reset
//     timer_irq  : level irq from the interval timer
//     bus        : Avalon-MM slave (address, chipselect, read_n, write_n,
//                  writedata, readdata with one-cycle latency)
//     irq        : logger interrupt, irq_en & (not_empty | overflow), registered
//   Register map: 0 STATUS, 1 CONTROL, 2/3 head index lo/hi, 4/5 head delta
//   lo/hi (reading 5 pops the head), 6 dropped-tick count.
//   Build option: define TICK_LOGGER_MISS_COUNT_EN to implement the 16-bit
//   saturating dropped-tick counter at address 6; otherwise address 6 reads 0.
// -----------------------------------------------------------------------------
module tick_event_logger
    import tick_logger_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   timer_irq,
    tick_event_logger_if.slave     bus,
    output logic                   irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]          control;
    logic                en;
    logic                irq_en;
    logic                irq_d;
    logic                rise;
    logic                wr;
    logic                pop;
    logic                push;
    logic                drop;
    logic                en_start;
    logic                overflow;
    logic [TS_WIDTH-1:0] index;
    logic [TS_WIDTH-1:0] cycle_cnt;
    tick_entry_t         head;
    tick_entry_t         new_entry;
    logic [LW-1:0]       level;
    logic                full;
    logic                empty;
    logic [15:0]         rd_mux;
    logic [15:0]         miss_rd;
    logic                unused_wdata;

    assign en        = control[CTRL_EN];
    assign irq_en    = control[CTRL_IRQ_EN];
    assign wr        = bus.chipselect & ~bus.write_n;
    assign rise      = timer_irq & ~irq_d & en;
    assign pop       = bus.chipselect & ~bus.read_n & (bus.address == ADDR_DELTA_HI) & ~empty;
    assign push      = rise & (~full | pop);
    assign drop      = rise & full & ~pop;
    // en is sampled before the write, so a rise in this cycle is never captured.
    assign en_start  = wr & (bus.address == ADDR_CONTROL) & bus.writedata[CTRL_EN] & ~en;
    assign new_entry = '{index: index, delta: cycle_cnt};

    assign unused_wdata = &{1'b0, bus.writedata[15:3]};

    tick_log_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (new_entry),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d     <= 1'b0;
            irq       <= 1'b0;
            control   <= '0;
            index     <= '0;
            cycle_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            irq_d <= timer_irq;
            irq   <= irq_en & (~empty | overflow);

            if (wr && bus.address == ADDR_CONTROL) control <= bus.writedata[1:0];

            // en_start needs en low and rise needs en high, so they never collide.
            if (en_start) begin
                index     <= '0;
                cycle_cnt <= '0;
            end else if (rise) begin
                index     <= index + 1'b1;
                cycle_cnt <= TS_WIDTH'(1);
            end else if (en && cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end

            // A drop in the same cycle as a clear leaves overflow set.
            if (drop)
                overflow <= 1'b1;
            else if (wr && bus.address == ADDR_STATUS && bus.writedata[STATUS_OVERFLOW])
                overflow <= 1'b0;
        end
    end

`ifdef TICK_LOGGER_MISS_COUNT_EN
    logic [15:0] miss_cnt;

    // A write clears the count; a drop in the same cycle still counts as one.
    always_ff @(posedge clk) begin
        if (reset)
            miss_cnt <= '0;
        else if (wr && bus.address == ADDR_MISS)
            miss_cnt <= drop ? 16'd1 : 16'd0;
        else if (drop && miss_cnt != '1)
            miss_cnt <= miss_cnt + 1'b1;
    end

    assign miss_rd = miss_cnt;
`else
    assign miss_rd = '0;
`endif

    // Read mux reflects state before this cycle's pop.
    // NOTE: rd_mux gets a default first so no path through the case infers a latch.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_STATUS: begin
                rd_mux[15:STATUS_LEVEL_LSB]  = 8'(level);
                rd_mux[STATUS_OVERFLOW]      = overflow;
                rd_mux[STATUS_FULL]          = full;
                rd_mux[STATUS_NOT_EMPTY]     = ~empty;
            end
            ADDR_CONTROL:  rd_mux[1:0] = control;
            ADDR_IDX_LO:   if (!empty) rd_mux = head.index[15:0];
            ADDR_IDX_HI:   if (!empty) rd_mux = head.index[31:16];
            ADDR_DELTA_LO: if (!empty) rd_mux = head.delta[15:0];
            ADDR_DELTA_HI: if (!empty) rd_mux = head.delta[31:16];
            ADDR_MISS:     rd_mux = miss_rd;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_mux;
    end

endmodule

// File: tb/tb_tick_event_logger.sv
// -----------------------------------------------------------------------------
// tb_tick_event_logger
//   Self-checking bench for tick_event_logger. Inputs change on the falling
//   edge; outputs are compared on the following falling edge. A queue-based
//   reference model tracks the logged ticks in terms of absolute cycle numbers.
// -----------------------------------------------------------------------------
module tb_tick_event_logger;
    import tick_logger_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic timer_irq = 1'b0;
    logic irq;

    tick_event_logger_if bus ();

    tick_event_logger #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .timer_irq (timer_irq),
        .bus       (bus),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    tick_entry_t mq[$];
    logic [31:0] m_idx;
    longint      m_ref;      // cycle from which the next delta is counted
    logic        m_ovf;
    logic [15:0] m_miss;
    logic [1:0]  m_ctrl;
    logic        m_prev_ti;
    longint      m_cyc = 0;  // number of the upcoming clock edge
    logic        ti_lvl = 1'b0;

    function automatic logic [15:0] model_read(input logic [2:0] a);
        logic [15:0] v;
        v = '0;
        case (a)
            3'd0: v = {8'(mq.size()), 5'b0, m_ovf, (mq.size() == DEPTH), (mq.size() != 0)};
            3'd1: v = {14'b0, m_ctrl};
            3'd2: if (mq.size() != 0) v = mq[0].index[15:0];
            3'd3: if (mq.size() != 0) v = mq[0].index[31:16];
            3'd4: if (mq.size() != 0) v = mq[0].delta[15:0];
            3'd5: if (mq.size() != 0) v = mq[0].delta[31:16];
`ifdef TICK_LOGGER_MISS_COUNT_EN
            3'd6: v = m_miss;
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    // Drive one cycle, advance the model, return what the DUT should show after the edge.
    task automatic cycle(input logic ti, input logic [2:0] a, input logic cs, input logic rdn,
                         input logic wrn, input logic [15:0] wd,
                         output logic [15:0] e_rd, output logic e_irq);
        bit rise, pop, wr, drop;
        timer_irq      = ti;
        bus.address    = a;
        bus.chipselect = cs;
        bus.read_n     = rdn;
        bus.write_n    = wrn;
        bus.writedata  = wd;

        e_rd  = model_read(a);
        e_irq = m_ctrl[1] & ((mq.size() != 0) | m_ovf);
        rise  = ti & ~m_prev_ti & m_ctrl[0];
        pop   = cs & ~rdn & (a == 3'd5) & (mq.size() != 0);
        wr    = cs & ~wrn;
        drop  = 0;
        if (pop) void'(mq.pop_front());
        if (rise) begin
            longint d;
            d = m_cyc - m_ref;
            if (d > 64'h0000_0000_FFFF_FFFF) d = 64'h0000_0000_FFFF_FFFF;
            if (mq.size() < DEPTH) mq.push_back('{index: m_idx, delta: 32'(d)});
            else begin
                drop  = 1;
                m_ovf = 1'b1;
                if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
            end
            m_idx = m_idx + 32'd1;
            m_ref = m_cyc;
        end
        if (wr && a == 3'd0 && wd[2] && !drop) m_ovf = 1'b0;
        if (wr && a == 3'd6) m_miss = drop ? 16'd1 : 16'd0;
        if (wr && a == 3'd1) begin
            if (wd[0] && !m_ctrl[0]) begin
                m_idx = '0;
                m_ref = m_cyc + 1;
            end
            m_ctrl = wd[1:0];
        end
        m_prev_ti = ti;
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input string name, input logic [2:0] a, input logic cs, input logic rdn,
                        input logic wrn, input logic [15:0] wd);
        logic [15:0] e_rd;
        logic        e_irq;
        cycle(ti_lvl, a, cs, rdn, wrn, wd, e_rd, e_irq);
        check({name, ".readdata"}, 32'(bus.readdata), 32'(e_rd));
        check({name, ".irq"}, 32'(irq), 32'(e_irq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 3'd0, 1'b0, 1'b1, 1'b1, 16'h0);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        step("write", a, 1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [15:0] v);
        step("read", a, 1'b1, 1'b0, 1'b1, 16'h0);
        v = bus.readdata;
    endtask

    task automatic pulse();
        ti_lvl = 1'b1;
        idle(1);
        ti_lvl = 1'b0;
        idle(1);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        timer_irq      = ti_lvl;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_idx     = '0;
        m_ref     = 0;
        m_ovf     = 1'b0;
        m_miss    = '0;
        m_ctrl    = '0;
        m_prev_ti = 1'b0;
        m_cyc++;
        check("reset.readdata", 32'(bus.readdata), 32'h0);
        check("reset.irq", 32'(irq), 32'h0);
    endtask

    typedef struct {
        logic        ti;
        logic [2:0]  a;
        logic        cs;
        logic        rdn;
        logic        wrn;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        irq;
    } vec_t;

    vec_t vecs[14];

    logic [15:0] v;
    logic [15:0] e_rd;
    logic        e_irq;
    logic [15:0] exp_miss;

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // ---------- table: register basics and a single tick ----------
        //            ti    a     cs    rdn   wrn   wd       rd        irq
        vecs[0]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 16'h3, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0003, 1'b0};
        vecs[4]  = '{1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0101, 1'b1};
        vecs[6]  = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0001, 1'b1};
        vecs[8]  = '{1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 3'd7, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 3'd6, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0000, 1'b0};
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].ti, vecs[i].a, vecs[i].cs, vecs[i].rdn, vecs[i].wrn, vecs[i].wd, e_rd, e_irq);
            check($sformatf("vec%0d.readdata", i), 32'(bus.readdata), 32'(vecs[i].rd));
            check($sformatf("vec%0d.irq", i), 32'(irq), 32'(vecs[i].irq));
        end

        // ---------- two ticks 250 cycles apart, then drain ----------
        do_reset();
        wr_reg(3'd1, 16'h0001);
        idle(98);
        pulse();
        idle(248);
        pulse();
        rd_reg(3'd0, v); check("two_ticks.status", 32'(v), 32'h0201);
        rd_reg(3'd2, v); check("two_ticks.idx0", 32'(v), 32'h0);
        rd_reg(3'd5, v);
        rd_reg(3'd0, v); check("two_ticks.status_after_pop", 32'(v), 32'h0101);
        rd_reg(3'd2, v); check("two_ticks.idx1", 32'(v), 32'h1);
        rd_reg(3'd4, v); check("two_ticks.delta1", 32'(v), 32'd250);
        rd_reg(3'd5, v); check("two_ticks.delta1_hi", 32'(v), 32'h0);
        rd_reg(3'd0, v); check("two_ticks.status_empty", 32'(v), 32'h0000);
        for (int a = 2; a <= 5; a++) begin
            rd_reg(3'(a), v);
            check($sformatf("empty_read%0d", a), 32'(v), 32'h0);
        end

        // ---------- overflow with 17 ticks ----------
        do_reset();
        wr_reg(3'd1, 16'h0001);
        for (int i = 0; i < 17; i++) pulse();
        rd_reg(3'd0, v); check("overflow.status", 32'(v), 32'h1007);
`ifdef TICK_LOGGER_MISS_COUNT_EN
        exp_miss = 16'd1;
`else
        exp_miss = 16'd0;
`endif
        rd_reg(3'd6, v); check("overflow.miss", 32'(v), 32'(exp_miss));
        ti_lvl = 1'b1; wr_reg(3'd0, 16'h0004); ti_lvl = 1'b0; idle(1);  // set beats clear
        ti_lvl = 1'b1; wr_reg(3'd6, 16'h0000); ti_lvl = 1'b0; idle(1);  // increment beats clear
        rd_reg(3'd0, v); check("overflow.set_wins", 32'(v), 32'h1007);
        rd_reg(3'd6, v); check("overflow.miss_after_clear", 32'(v), 32'(exp_miss));
        for (int i = 0; i < 16; i++) begin
            rd_reg(3'd2, v); check($sformatf("overflow.idx%0d", i), 32'(v), 32'(i));
            rd_reg(3'd5, v);
        end
        rd_reg(3'd0, v); check("overflow.sticky", 32'(v), 32'h0004);

        // ---------- push and pop together while full ----------
        do_reset();
        wr_reg(3'd1, 16'h0001);
        for (int i = 0; i < 16; i++) pulse();
        rd_reg(3'd0, v); check("full.status", 32'(v), 32'h1003);
        ti_lvl = 1'b1; rd_reg(3'd5, v); ti_lvl = 1'b0;
        rd_reg(3'd0, v); check("full.pushpop_status", 32'(v), 32'h1003);
        for (int i = 0; i < 16; i++) begin
            rd_reg(3'd2, v); check($sformatf("full.idx%0d", i + 1), 32'(v), 32'(i + 1));
            rd_reg(3'd5, v);
        end

        // ---------- interrupt behaviour ----------
        do_reset();
        wr_reg(3'd1, 16'h0003);
        pulse();
        check("irq.one_entry", 32'(irq), 32'h1);
        rd_reg(3'd5, v);
        idle(1);
        check("irq.after_pop", 32'(irq), 32'h0);
        for (int i = 0; i < 17; i++) pulse();
        for (int i = 0; i < 16; i++) rd_reg(3'd5, v);
        idle(1);
        check("irq.overflow_only", 32'(irq), 32'h1);
        wr_reg(3'd0, 16'h0004);
        idle(1);
        check("irq.overflow_cleared", 32'(irq), 32'h0);
        rd_reg(3'd0, v); check("irq.status_cleared", 32'(v), 32'h0000);

        // ---------- reset mid-stream with timer_irq held high ----------
        do_reset();
        wr_reg(3'd1, 16'h0001);
        for (int i = 0; i < 5; i++) pulse();
        ti_lvl = 1'b1;
        idle(2);
        do_reset();
        rd_reg(3'd0, v); check("midreset.status", 32'(v), 32'h0000);
        rd_reg(3'd1, v); check("midreset.control", 32'(v), 32'h0000);
        wr_reg(3'd1, 16'h0001);
        idle(5);
        rd_reg(3'd0, v); check("midreset.no_rise_while_high", 32'(v), 32'h0000);
        ti_lvl = 1'b0; idle(1);
        ti_lvl = 1'b1; idle(1);
        rd_reg(3'd0, v); check("midreset.rise_after_drop", 32'(v), 32'h0101);
        ti_lvl = 1'b0;

        // ---------- randomized traffic against the model ----------
        do_reset();
        wr_reg(3'd1, {14'b0, 1'($urandom_range(0, 1)), 1'b1});
        for (int n = 0; n < 3000; n++) begin
            int op;
            if ($urandom_range(0, 3) == 0) ti_lvl = ~ti_lvl;
            op = int'($urandom_range(0, 9));
            case (op)
                4, 5:    step("rand.read", 3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b1, 16'h0);
                6:       step("rand.pop", 3'd5, 1'b1, 1'b0, 1'b1, 16'h0);
                7:       step("rand.wstatus", 3'd0, 1'b1, 1'b1, 1'b0, 16'($urandom));
                8:       step("rand.wmiss", 3'd6, 1'b1, 1'b1, 1'b0, 16'($urandom));
                9:       step("rand.wctrl", 3'd1, 1'b1, 1'b1, 1'b0,
                              {14'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)});
                default: step("rand.idle", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                              1'b1, 1'b1, 16'h0);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
